pipe_stage_chain: RTL and testbench

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

---
 rtl/pipe_stage_chain.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_chain.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_chain
// Brief   : DEPTH-stage valid/ready register chain with optional 2-entry skid.
// Revision: 1.0
// ============================================================================
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int SKID  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+3)-1:0]   occupancy
);
    localparam int OCC_W = $clog2(DEPTH+3);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] data [DEPTH];
    logic             out_xfer;
    logic             in_xfer;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign out_xfer  = out_valid && out_ready;
    assign in_xfer   = in_valid && in_ready && !flush;

    // A stage may load when empty or when its contents move on downstream.
    always_comb begin
        load            = '0;
        load[DEPTH-1]   = !valid[DEPTH-1] || out_xfer;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            load[k] = !valid[k] || load[k+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (load[0]) begin
                valid[0] <= src_valid;
                if (src_valid) begin
                    data[0] <= src_data;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    valid[k] <= valid[k-1];
                    if (valid[k-1]) begin
                        data[k] <= data[k-1];
                    end
                end
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid0;
            logic [WIDTH-1:0] skid1;
            logic [1:0]       skid_cnt;
            logic [1:0]       cnt_next;
            logic             ready_q;
            logic             push;
            logic             pop;

            // Words park in the skid whenever it already holds older words or
            // stage 0 is blocked, so stage 0 always drains it in FIFO order.
            assign pop       = (skid_cnt != 2'd0) && load[0];
            assign push      = in_xfer && ((skid_cnt != 2'd0) || !load[0]);
            assign src_valid = (skid_cnt != 2'd0) || in_xfer;
            assign src_data  = (skid_cnt != 2'd0) ? skid0 : in_data;
            assign cnt_next  = flush ? 2'd0 : (skid_cnt + 2'(push) - 2'(pop));
            assign in_ready  = ready_q && !reset;

            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_cnt <= 2'd0;
                    skid0    <= '0;
                    skid1    <= '0;
                    ready_q  <= 1'b1;
                end else begin
                    skid_cnt <= cnt_next;
                    ready_q  <= (cnt_next < 2'd2);
                    if (!flush) begin
                        case ({push, pop})
                            2'b11: begin
                                if (skid_cnt == 2'd1) begin
                                    skid0 <= in_data;
                                end else begin
                                    skid0 <= skid1;
                                    skid1 <= in_data;
                                end
                            end
                            2'b01: begin
                                if (skid_cnt == 2'd2) begin
                                    skid0 <= skid1;
                                end
                            end
                            2'b10: begin
                                if (skid_cnt == 2'd0) begin
                                    skid0 <= in_data;
                                end else begin
                                    skid1 <= in_data;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end else begin : g_noskid
            assign src_valid = in_xfer;
            assign src_data  = in_data;
            assign in_ready  = !reset && load[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stage_chain
// Brief   : Seven chain configurations on shared stimulus, FIFO scoreboard each.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_chain;
    localparam int N    = 7;
    localparam int I_D3 = 0;   // DEPTH=3 SKID=0
    localparam int I_D2 = 1;   // DEPTH=2 SKID=1
    localparam int I_D4 = 2;   // DEPTH=4 SKID=0
    localparam int I_D1 = 3;   // DEPTH=1 SKID=0
    localparam int I_D8 = 4;   // DEPTH=8 SKID=0
    localparam int I_S1 = 5;   // DEPTH=1 SKID=1
    localparam int I_S8 = 6;   // DEPTH=8 SKID=1

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    logic        ir [N];
    logic        ov [N];
    logic [31:0] od [N];
    logic [3:0]  oc [N];
    logic [2:0]  occ_a, occ_b, occ_c;
    logic [1:0]  occ_d, occ_f;
    logic [3:0]  occ_e, occ_g;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [N][$];

    always #5 clk = ~clk;

    assign oc[I_D3] = {1'b0, occ_a};
    assign oc[I_D2] = {1'b0, occ_b};
    assign oc[I_D4] = {1'b0, occ_c};
    assign oc[I_D1] = {2'b00, occ_d};
    assign oc[I_D8] = occ_e;
    assign oc[I_S1] = {2'b00, occ_f};
    assign oc[I_S8] = occ_g;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .SKID(0)) u_d3 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_D3]), .out_valid(ov[I_D3]),
        .out_data(od[I_D3]), .out_ready(out_ready), .occupancy(occ_a));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(2), .SKID(1)) u_d2 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_D2]), .out_valid(ov[I_D2]),
        .out_data(od[I_D2]), .out_ready(out_ready), .occupancy(occ_b));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .SKID(0)) u_d4 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_D4]), .out_valid(ov[I_D4]),
        .out_data(od[I_D4]), .out_ready(out_ready), .occupancy(occ_c));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(1), .SKID(0)) u_d1 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_D1]), .out_valid(ov[I_D1]),
        .out_data(od[I_D1]), .out_ready(out_ready), .occupancy(occ_d));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(8), .SKID(0)) u_d8 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_D8]), .out_valid(ov[I_D8]),
        .out_data(od[I_D8]), .out_ready(out_ready), .occupancy(occ_e));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(1), .SKID(1)) u_s1 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_S1]), .out_valid(ov[I_S1]),
        .out_data(od[I_S1]), .out_ready(out_ready), .occupancy(occ_f));
    pipe_stage_chain #(.WIDTH(32), .DEPTH(8), .SKID(1)) u_s8 (.clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir[I_S8]), .out_valid(ov[I_S8]),
        .out_data(od[I_S8]), .out_ready(out_ready), .occupancy(occ_g));

    // Scoreboard: check the state left by the last edge, then apply this
    // cycle's handshakes so the queues describe the state after the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (oc[i] !== 4'(sb[i].size())) begin
                n_fail++;
                $display("FAIL sb_occ[%0d] t=%0t: got %0d want %0d", i, $time, oc[i], sb[i].size());
            end
            n_checks++;
            if ($isunknown(ov[i])) begin
                n_fail++;
                $display("FAIL sb_valid_x[%0d] t=%0t: got %b want 0/1", i, $time, ov[i]);
            end
            if (ov[i] === 1'b1) begin
                n_checks++;
                if (sb[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_spurious[%0d] t=%0t: got %h want no output", i, $time, od[i]);
                end else if (od[i] !== sb[i][0]) begin
                    n_fail++;
                    $display("FAIL sb_data[%0d] t=%0t: got %h want %h", i, $time, od[i], sb[i][0]);
                end
            end
            if (reset) begin
                sb[i].delete();
            end else begin
                if (ov[i] === 1'b1 && out_ready && sb[i].size() > 0) void'(sb[i].pop_front());
                if (flush) sb[i].delete();
                else if (in_valid && ir[i] === 1'b1) sb[i].push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ir[i] !== 1'b0 || ov[i] !== 1'b0 || oc[i] !== 4'd0 || od[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got rdy=%b v=%b occ=%0d d=%h want 0 0 0 0",
                         i, ir[i], ov[i], oc[i], od[i]);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (ir[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got %b want 1", i, ir[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_o [4] = '{4'd1, 4'd1, 4'd1, 4'd0};
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
        for (int e = 0; e < 4; e++) begin
            step();
            in_valid = 1'b0;
            n_checks++;
            if (ov[I_D3] !== exp_v[e] || oc[I_D3] !== exp_o[e]) begin
                n_fail++;
                $display("FAIL latency_e%0d: got v=%b occ=%0d want v=%b occ=%0d",
                         e, ov[I_D3], oc[I_D3], exp_v[e], exp_o[e]);
            end
            if (e == 2) begin
                n_checks++;
                if (od[I_D3] !== 32'hA5A5_A5A5) begin
                    n_fail++;
                    $display("FAIL latency_data: got %h want a5a5a5a5", od[I_D3]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            in_valid = (c < 10);
            in_data  = 32'(c + 1);
            if (c < 10) begin
                n_checks++;
                if (ir[I_D2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready_c%0d: got %b want 1", c, ir[I_D2]);
                end
            end
            step();
            if (c >= 1) begin
                n_checks++;
                if (ov[I_D2] !== 1'b1 || od[I_D2] !== 32'(c)) begin
                    n_fail++;
                    $display("FAIL stream_out_c%0d: got v=%b d=%0d want v=1 d=%0d", c, ov[I_D2], od[I_D2], c);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        drain();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (ir[I_D2] !== 1'b1) break;
            n++;
            in_valid = 1'b1; in_data = 32'(n);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (n != 4 || oc[I_D2] !== 4'd4) begin
            n_fail++;
            $display("FAIL bp_fill: got accepted=%0d occ=%0d want 4 4", n, oc[I_D2]);
        end
        repeat (2) step();
        n_checks++;
        if (ov[I_D2] !== 1'b1 || od[I_D2] !== 32'd1 || ir[I_D2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b d=%0d rdy=%b want 1 1 0", ov[I_D2], od[I_D2], ir[I_D2]);
        end
        out_ready = 1'b1;
        for (int w = 2; w <= 5; w++) begin
            step();
            n_checks++;
            if ((w <= 4 && (ov[I_D2] !== 1'b1 || od[I_D2] !== 32'(w))) || (w == 5 && ov[I_D2] !== 1'b0)) begin
                n_fail++;
                $display("FAIL bp_drain_w%0d: got v=%b d=%0d want word %0d", w, ov[I_D2], od[I_D2], w);
            end
        end
    endtask

    task automatic test_flush();
        drain();
        out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            in_valid = 1'b1; in_data = 32'(w * 17);
            step();
        end
        n_checks++;
        if (oc[I_D4] !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_fill: got occ=%0d want 3", oc[I_D4]);
        end
        flush = 1'b1; in_data = 32'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (oc[I_D4] !== 4'd0 || ov[I_D4] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear: got occ=%0d v=%b want 0 0", oc[I_D4], ov[I_D4]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (ov[I_D4] !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak_c%0d: got v=%b d=%h want no output", c, ov[I_D4], od[I_D4]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drain();
        out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            in_valid = 1'b1; in_data = 32'h200 + 32'(w);
            step();
        end
        in_valid = 1'b0;
        n_checks++;
        if (oc[I_D3] !== 4'd3) begin
            n_fail++;
            $display("FAIL mid_fill: got occ=%0d want 3", oc[I_D3]);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ov[I_D3] !== 1'b0 || od[I_D3] !== 32'd0 || oc[I_D3] !== 4'd0 || ir[I_D3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b d=%h occ=%0d rdy=%b want 0 0 0 1",
                     ov[I_D3], od[I_D3], oc[I_D3], ir[I_D3]);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h101;
        step();
        in_data = 32'h102;
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (ov[I_D3] !== 1'b1 || od[I_D3] !== 32'h101) begin
            n_fail++;
            $display("FAIL mid_after1: got v=%b d=%h want 1 101", ov[I_D3], od[I_D3]);
        end
        step();
        n_checks++;
        if (ov[I_D3] !== 1'b1 || od[I_D3] !== 32'h102) begin
            n_fail++;
            $display("FAIL mid_after2: got v=%b d=%h want 1 102", ov[I_D3], od[I_D3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0) || (c % 200 > 150);
            flush     = ($urandom_range(0, 59) == 0);
            step();
        end
        drain();
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (oc[i] !== 4'd0 || ov[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_final[%0d]: got occ=%0d v=%b want 0 0", i, oc[i], ov[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
